// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request channel and a valid/ready
// response channel; every request completes after a fixed, parameterised latency.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 16,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_U  = 30'(DEPTH_WORDS);
    localparam logic [2:0]  CNT_LOAD = 3'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_s;
    logic        accept_s;
    logic        exec_s;

    logic        cap_write_r;
    logic [31:0] cap_addr_r;
    logic [31:0] cap_wdata_r;
    logic [3:0]  cap_wstrb_r;

    logic        op_write_s;
    logic [31:0] op_addr_s;
    logic [31:0] op_wdata_s;
    logic [3:0]  op_wstrb_s;
    logic        op_err_s;
    logic [IDX_W-1:0] op_idx_s;
    logic [31:0] op_pattern_s;
    logic [31:0] cur_word_s;
    logic [31:0] new_word_s;
    logic        mem_we_s;

    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    // Each word stores its difference from the power-up pattern, so an array that
    // starts out all-zero reads back as byte i = i mod 256 without any reset.
    logic [31:0] mem_r [0:DEPTH_WORDS-1];

    // Power-up contents of the word whose low byte address is {word_lsb, 2'b00}.
    function automatic logic [31:0] pattern_word(input logic [5:0] word_lsb);
        logic [7:0] base;
        base = {word_lsb, 2'b00};
        return {base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    // Replace the bytes selected by strb with the matching bytes of wdata.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return merged;
    endfunction

    // Next-state and counter logic of the request sequencer.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        exec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_s = ST_RESP;
                        exec_s  = 1'b1;
                    end else begin
                        state_s = ST_BUSY;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 3'd0) begin
                    state_s = ST_RESP;
                    exec_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // Operand selection and memory datapath; with LATENCY=1 the access executes on the
    // accept edge, so the live request fields are used instead of the captured ones.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_write_s = req_write;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
            op_wstrb_s = req_wstrb;
        end else begin
            op_write_s = cap_write_r;
            op_addr_s  = cap_addr_r;
            op_wdata_s = cap_wdata_r;
            op_wstrb_s = cap_wstrb_r;
        end
        op_err_s     = (op_addr_s[1:0] != 2'b00) || (op_addr_s[31:2] >= DEPTH_U);
        op_idx_s     = op_addr_s[IDX_W+1:2];
        op_pattern_s = pattern_word(op_addr_s[7:2]);
        cur_word_s   = mem_r[op_idx_s] ^ op_pattern_s;
        new_word_s   = merge_bytes(cur_word_s, op_wdata_s, op_wstrb_s);
        mem_we_s     = exec_s & op_write_s & ~op_err_s & rst;
    end

    // Memory array write port; deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[op_idx_s] <= new_word_s ^ op_pattern_s;
        end
    end

    // Sequencer state, down-counter and registered handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
        end
    end

    // Request capture on the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_write_r <= 1'b0;
            cap_addr_r  <= 32'd0;
            cap_wdata_r <= 32'd0;
            cap_wstrb_r <= 4'd0;
        end else if (accept_s) begin
            cap_write_r <= req_write;
            cap_addr_r  <= req_addr;
            cap_wdata_r <= req_wdata;
            cap_wstrb_r <= req_wstrb;
        end
    end

    // Response payload: loaded when entering RESP, cleared after the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else if (exec_s) begin
            rsp_rdata_r <= (op_err_s || op_write_s) ? 32'd0 : cur_word_s;
            rsp_err_r   <= op_err_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a transaction-level byte-array model checked every
// cycle, directed cases with literal expectations, random traffic and a LATENCY=3 stream.
module tb_data_mem_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 2;
    localparam int LAT3  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        rst3, req_valid3, req_ready3, req_write3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [31:0] req_addr3, req_wdata3, rsp_rdata3;
    logic [3:0]  req_wstrb3;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write3), .req_addr(req_addr3), .req_wdata(req_wdata3),
        .req_wstrb(req_wstrb3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    int checks = 0;
    int errors = 0;
    bit stream_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory plus one outstanding transaction.
    logic [7:0]  mem_m [0:DEPTH*4-1];
    bit          pend = 1'b0, done = 1'b0;
    int          rem;
    logic        m_w;
    logic [31:0] m_a, m_d, exp_data;
    logic [3:0]  m_s;
    logic        exp_err;

    initial for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'(i);

    function automatic void exec_model();
        int b;
        if (m_a[1:0] != 2'b00 || (m_a >> 2) >= 32'(DEPTH)) begin
            exp_err = 1'b1; exp_data = 32'd0;
        end else begin
            b = int'(m_a);
            exp_err = 1'b0;
            if (m_w) begin
                for (int k = 0; k < 4; k++) if (m_s[k]) mem_m[b+k] = m_d[8*k +: 8];
                exp_data = 32'd0;
            end else begin
                exp_data = {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
            end
        end
    endfunction

    // Compare the DUT against the model every cycle, then advance the model one edge.
    always @(negedge clk) begin
        if (!rst) begin
            pend = 1'b0;
            done = 1'b0;
        end else begin
            chk("req_ready", 32'(req_ready), 32'(!pend));
            chk("rsp_valid", 32'(rsp_valid), 32'(pend && done));
            if (pend && done) begin
                chk("rsp_rdata", rsp_rdata, exp_data);
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            if (!pend) begin
                if (req_valid) begin
                    pend = 1'b1; done = 1'b0;
                    m_w = req_write; m_a = req_addr; m_d = req_wdata; m_s = req_wstrb;
                    rem = LAT - 1;
                    if (rem == 0) begin exec_model(); done = 1'b1; end
                end
            end else if (!done) begin
                rem--;
                if (rem == 0) begin exec_model(); done = 1'b1; end
            end else if (rsp_ready) begin
                pend = 1'b0;
            end
        end
    end

    task automatic finish_rsp(input int hold, output logic [31:0] rd, output logic er,
                              output int lat);
        bit ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("rsp_timeout", 32'(ok), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, input bit bg,
                        output logic [31:0] rd, output logic er, output int lat);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (bg) begin
            req_write = 1'b0; req_addr = 32'h20; req_wdata = $urandom; req_wstrb = 4'hF;
        end else begin
            req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
            req_wdata = $urandom; req_wstrb = 4'($urandom);
        end
        finish_rsp(hold, rd, er, lat);
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        er;
        int          lat;
        bit          ok;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_wstrb = 4'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        send(1'b0, 32'h4, 32'h0, 4'hF, 1, 1'b0, rd, er, lat);
        chk("load4_data", rd, 32'h07060504);
        chk("load4_err", 32'(er), 32'd0);
        chk("load4_latency", 32'(lat), 32'd2);

        send(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 2, 1'b0, rd, er, lat);
        chk("store8_data", rd, 32'd0);
        chk("store8_err", 32'(er), 32'd0);
        send(1'b0, 32'h8, 32'h0, 4'hF, 1, 1'b0, rd, er, lat);
        chk("load8_data", rd, 32'h0BBB09DD);

        send(1'b0, 32'hC, 32'hFFFFFFFF, 4'h0, 1, 1'b0, rd, er, lat);
        chk("loadC_nostrb", rd, 32'h0F0E0D0C);

        send(1'b0, 32'h6, 32'h0, 4'hF, 1, 1'b0, rd, er, lat);
        chk("load6_err", 32'(er), 32'd1);
        chk("load6_data", rd, 32'd0);
        send(1'b1, 32'h40, 32'h12345678, 4'hF, 1, 1'b0, rd, er, lat);
        chk("store40_err", 32'(er), 32'd1);
        send(1'b1, 32'hFFFFFFFC, 32'h12345678, 4'hF, 1, 1'b0, rd, er, lat);
        chk("storeTop_err", 32'(er), 32'd1);
        send(1'b0, 32'h3C, 32'h0, 4'hF, 1, 1'b0, rd, er, lat);
        chk("load3C_data", rd, 32'h3F3E3D3C);
        chk("load3C_err", 32'(er), 32'd0);
        send(1'b1, 32'h0, 32'hDEADBEEF, 4'h0, 1, 1'b0, rd, er, lat);
        chk("store0_nostrb_err", 32'(er), 32'd0);

        // Backpressure with a competing request held on the request channel.
        send(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, rd, er, lat);
        chk("bp_first_data", rd, 32'h13121110);
        @(posedge clk);
        #1 req_valid = 1'b0;
        finish_rsp(1, rd, er, lat);
        chk("bp_second_data", rd, 32'h23222120);
        chk("bp_second_latency", 32'(lat), 32'd2);

        // Reset while a store sits in BUSY.
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0;
        req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("rst_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        send(1'b0, 32'h0, 32'h0, 4'hF, 1, 1'b0, rd, er, lat);
        chk("load0_after_rst", rd, 32'h03020100);

        // Random traffic checked by the model.
        for (int n = 0; n < 40; n++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 6) begin
                a = 32'($urandom_range(0, DEPTH-1)) << 2;
            end else if (r < 8) begin
                a = (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(1, 3));
            end else begin
                a = $urandom;
                a[1:0] = 2'b00;
                if (a < 32'(DEPTH*4)) a = a + 32'(DEPTH*4);
            end
            send(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(1, 3)),
                 1'b0, rd, er, lat);
        end

        wait (stream_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Back-to-back loads on the LATENCY=3 instance.
    initial begin
        logic [31:0] q[$];
        logic [31:0] a, e;
        int last = -1, nacc = 0, nrsp = 0;
        bit acc;
        rst3 = 1'b0; req_valid3 = 1'b0; rsp_ready3 = 1'b1; req_write3 = 1'b0;
        req_wdata3 = 32'd0; req_wstrb3 = 4'd0; req_addr3 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst3 = 1'b1; req_valid3 = 1'b1;
        req_addr3 = 32'($urandom_range(0, DEPTH-1)) << 2;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            acc = 1'b0;
            if (rsp_valid3) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    a = q.pop_front();
                    e = {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
                    chk("stream_rdata", rsp_rdata3, e);
                    chk("stream_err", 32'(rsp_err3), 32'd0);
                    nrsp++;
                end
            end
            if (req_valid3 && req_ready3) begin
                q.push_back(req_addr3);
                if (last >= 0) chk("stream_spacing", 32'(i - last), 32'(LAT3 + 1));
                last = i;
                nacc++;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) req_addr3 = 32'($urandom_range(0, DEPTH-1)) << 2;
        end
        req_valid3 = 1'b0;
        chk("stream_accepts", 32'(nacc), 32'(80 / (LAT3 + 1)));
        chk("stream_responses", 32'(nrsp), 32'(80 / (LAT3 + 1)));
        stream_done = 1'b1;
    end

endmodule
